pe_data_extender: RTL
=====================

// Module: pe_data_extender
// PURPOSE
//  Parametrised single-clock beat buffer and extender in the clk_pe domain, feeding PE arrays.
//  Queues incoming data beats in a FIFO, then presents each beat to the PE for a programmable
//  number of accepted repeats. Output uses a valid/ready handshake.
//  Supports per-beat hold counts, back-pressure, flush, and sticky overflow reporting.
// PARAMETERS
//  DATA_W   256  width of one data beat
//  DEPTH    4    FIFO entries; power of two, >= 2
//  HOLD_W   4    width of per-beat repeat count (max repeats 2**HOLD_W-1)
// PORTS
//  clk_pe        in   1                 single clock; all logic on posedge
//  rst           in   1                 synchronous, active-high reset
//  flush_i       in   1                 synchronous clear of FIFO, output stage and flags
//  data_valid_i  in   1                 input beat valid
//  data_i        in   DATA_W            input beat
//  hold_i        in   HOLD_W            repeat count for this beat; 0 treated as 1
//  data_ready_o  out  1                 FIFO can accept (= !full && !flush_i)
//  data_valid_o  out  1                 output beat valid
//  data_o        out  DATA_W            output beat
//  data_ready_i  in   1                 PE accepts output this cycle
//  level_o       out  $clog2(DEPTH+1)   FIFO occupancy (excludes beat in output stage)
//  overflow_o    out  1                 sticky: push attempted while full
// BEHAVIOUR
//  Reset (rst=1 at posedge): data_valid_o=0, data_o=0, level_o=0, overflow_o=0, FSM=IDLE, rep_cnt=0.
//  Push: data_valid_i && data_ready_o writes {data_i, hold_i} to the tail.
//   data_ready_o does not depend on the same-cycle pop; a full FIFO is never written.
//  Overflow: data_valid_i && full && !flush_i sets overflow_o. The beat is dropped.
//   overflow_o stays set until rst or flush_i.
//  FSM states:
//   IDLE: data_valid_o=0. If FIFO is non-empty, pop the head into the output register,
//    load rep_cnt = max(hold,1), go to SEND.
//   SEND: data_valid_o=1; data_o holds the beat stable. Each cycle with data_ready_i=1
//    decrements rep_cnt.
//  SEND transitions, when rep_cnt==1 and data_ready_i=1:
//   FIFO non-empty -> pop the next beat on the same edge and stay in SEND (no bubble).
//   FIFO empty -> go to IDLE and clear data_valid_o.
//  While data_ready_i=0, data_o, data_valid_o and rep_cnt hold.
//  Latency: a push into an empty FIFO with the FSM in IDLE at edge t gives data_valid_o=1
//   after edge t+1 (2-cycle first-word latency). Sustained throughput is 1 accepted repeat per cycle.
//  Simultaneous push and pop: level_o is unchanged, both take effect, and order is preserved.
//  Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty come from level_o.
//  flush_i has priority over push, pop and overflow. On the next edge: FIFO empty,
//   FSM=IDLE, data_valid_o=0, overflow_o=0, level_o=0. data_o keeps its last value.
//  rst mid-burst: same as flush, plus data_o is cleared to 0.
//  hold_i is sampled at push time and stored per entry. Later changes do not affect queued beats.
// STRUCTURE
//  pe_sync_pkg: typedef struct packed {logic [DATA_W-1:0] data; logic [HOLD_W-1:0] hold;} beat_t.
//   The package also holds localparams for the default DATA_W/HOLD_W and the FSM state enum
//   {IDLE, SEND}.
//  Sub-module pe_sync_fifo: single-clock register FIFO of beat_t. Ports: push, pop, flush,
//   level, full, empty.
//  Top level: FSM, rep_cnt counter, output register and overflow flag.
// TESTING
//  1. Single beat: push D=0xA5.., hold=3 with data_ready_i=1 -> valid_o for exactly 3 cycles,
//     first at edge t+2, then IDLE.
//  2. Back-to-back: push beats A(hold=1), B(hold=2), C(hold=0) -> output A,B,B,C with no
//     bubbles; C is shown once.
//  3. Back-pressure: hold data_ready_i=0 for 5 cycles mid-repeat -> data_o and rep_cnt frozen;
//     the remaining repeats resume with no loss.
//  4. Full/overflow: DEPTH=4, data_ready_i=0 -> after 5 beats (4 queued plus 1 in the output
//     stage) data_ready_o=0 and level_o=4. A 6th push sets overflow_o and the beat is never output.
//  5. Flush mid-burst: queue 3 beats, assert flush_i with data_valid_i=1 -> next cycle
//     data_valid_o=0, level_o=0, overflow_o=0; the pushed beat is dropped.
//  6. Reset mid-SEND: rst=1 for one cycle -> data_o=0, data_valid_o=0. A post-reset push
//     behaves as in test 1.

Source files
------------

// File: rtl/pe_sync_pkg.sv
// Shared types for the PE beat extender: default widths, beat record and FSM states.
package pe_sync_pkg;

    localparam int unsigned DATA_W_DEF = 256;
    localparam int unsigned HOLD_W_DEF = 4;

    // One queued beat at the default widths: payload plus its repeat count.
    typedef struct packed {
        logic [DATA_W_DEF-1:0] data;
        logic [HOLD_W_DEF-1:0] hold;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/pe_sync_fifo.sv
// Single-clock register FIFO. Head word is visible combinationally on rdata.
// Full/empty are derived from the occupancy counter; pointers wrap naturally.
module pe_sync_fifo #(
    parameter int unsigned WIDTH = 260,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_push;
    logic w_pop;

    assign full    = (r_level == LVL_W'(DEPTH));
    assign empty   = (r_level == '0);
    assign level   = r_level;
    assign rdata   = r_mem[r_rd_ptr];
    assign w_push  = push && !full && !flush;
    assign w_pop   = pop && !empty && !flush;

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; flush empties the queue like reset does.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/pe_data_extender.sv
// Beat buffer and extender: queues beats, then shows each one to the PE for
// max(hold,1) accepted repeats over a valid/ready handshake.
module pe_data_extender
    import pe_sync_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned HOLD_W = HOLD_W_DEF
) (
    input  logic                       clk_pe,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       data_valid_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic [HOLD_W-1:0]          hold_i,
    output logic                       data_ready_o,
    output logic                       data_valid_o,
    output logic [DATA_W-1:0]          data_o,
    input  logic                       data_ready_i,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       overflow_o
);

    localparam int unsigned BEAT_W = DATA_W + HOLD_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [HOLD_W-1:0] hold;
    } ext_beat_t;

    state_t              r_state;
    logic [HOLD_W-1:0]   r_rep_cnt;
    logic [DATA_W-1:0]   r_data;
    logic                r_valid;
    logic                r_overflow;

    ext_beat_t           w_wbeat;
    ext_beat_t           w_head;
    logic [BEAT_W-1:0]   w_rdata;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_last_rep;
    logic [HOLD_W-1:0]   w_head_reps;

    assign w_wbeat      = '{data: data_i, hold: hold_i};
    assign w_head       = ext_beat_t'(w_rdata);
    assign w_head_reps  = (w_head.hold == '0) ? HOLD_W'(1) : w_head.hold;

    assign data_ready_o = !w_full && !flush_i;
    assign w_push       = data_valid_i && data_ready_o;
    assign w_last_rep   = data_ready_i && (r_rep_cnt == HOLD_W'(1));
    // Pop from IDLE, or on the final accepted repeat so the next beat follows with no bubble.
    assign w_pop        = !flush_i && !w_empty &&
                          ((r_state == IDLE) || ((r_state == SEND) && w_last_rep));

    assign data_valid_o = r_valid;
    assign data_o       = r_data;
    assign overflow_o   = r_overflow;

    pe_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk_pe),
        .rst   (rst),
        .flush (flush_i),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wbeat),
        .rdata (w_rdata),
        .level (level_o),
        .full  (w_full),
        .empty (w_empty)
    );

    // Output FSM, repeat counter, output register and sticky overflow flag.
    always_ff @(posedge clk_pe) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_rep_cnt  <= '0;
            r_overflow <= 1'b0;
        end else if (flush_i) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_rep_cnt  <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (data_valid_i && w_full) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_data    <= w_head.data;
                        r_rep_cnt <= w_head_reps;
                        r_valid   <= 1'b1;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    if (data_ready_i) begin
                        if (r_rep_cnt == HOLD_W'(1)) begin
                            if (!w_empty) begin
                                r_data    <= w_head.data;
                                r_rep_cnt <= w_head_reps;
                            end else begin
                                r_rep_cnt <= '0;
                                r_valid   <= 1'b0;
                                r_state   <= IDLE;
                            end
                        end else begin
                            r_rep_cnt <= r_rep_cnt - HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
